// File: rtl/prio_arb_mux_if.sv
// Handshake bundle for prio_arb_mux: per-channel request side and single
// registered output side. The arbiter connects through the slave modport.
interface prio_arb_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_chan;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/prio_arb_mux.sv
// N-channel priority / round-robin arbiter with a single registered output
// stage; one beat per cycle, no internal buffering beyond that register.
module prio_arb_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic           clk,
    input logic           rst_n,
    input logic           mode,
    prio_arb_mux_if.slave bus
);
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_next;
    logic              load;
    logic              xfer;
    int unsigned       pos;

    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_chan_q;
    logic              out_valid_q;

    always_comb begin
        for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
            ch_data[i] = bus.in_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts at 0 (fixed) or rr_ptr (round-robin), wrapping once.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        for (int unsigned k = 0; k < unsigned'(NUM_CH); k++) begin
            pos = k;
            if (mode) begin
                pos = k + 32'(rr_ptr);
            end
            if (pos >= unsigned'(NUM_CH)) begin
                pos = pos - unsigned'(NUM_CH);
            end
            if (!gnt_any && bus.in_valid[pos]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(pos);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        if (gnt_idx == IDX_W'(NUM_CH - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = gnt_idx + 1'b1;
        end
    end

    assign load = ~out_valid_q | bus.out_ready;
    assign xfer = gnt_any & load & rst_n;

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign bus.in_ready  = (rst_n && load) ? grant : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (xfer) begin
                out_data_q  <= ch_data[gnt_idx];
                out_chan_q  <= gnt_idx;
                out_valid_q <= 1'b1;
                if (mode) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prio_arb_mux.sv
// Self-checking bench for prio_arb_mux: directed scenarios plus randomized
// traffic compared against a queue-based arbitration model.
module tb_prio_arb_mux;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int IW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic mode;
    int   vectors     = 0;
    int   miscompares = 0;

    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_chan;
    int            m_rr;

    prio_arb_mux_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    prio_arb_mux #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Priority order as an explicit list of channel numbers; first valid wins.
    function automatic int exp_grant();
        int order[$];
        for (int k = 0; k < NCH; k++) begin
            order.push_back(mode ? (m_rr + k) % NCH : k);
        end
        foreach (order[j]) begin
            if (bus.in_valid[order[j]]) return order[j];
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_ready();
        int g;
        if (rst_n !== 1'b1) return '0;
        if (m_valid && !bus.out_ready) return '0;
        g = exp_grant();
        if (g < 0) return '0;
        return NCH'(1) << g;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_rr    = 0;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] val);
        bus.in_data[ch*DW +: DW] = val;
    endtask

    // One clock: model state advances with the same pre-edge inputs as the DUT.
    task automatic step();
        int   g;
        bit   ld;
        logic [DW-1:0] d;
        g  = exp_grant();
        ld = !m_valid || bus.out_ready;
        d  = (g >= 0) ? bus.in_data[g*DW +: DW] : '0;
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d;
                m_chan  = g;
                if (mode) m_rr = (g + 1) % NCH;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        bus.in_valid = 4'hF;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h want 00", bus.out_data);
        end
        vectors++;
        if (bus.out_chan !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_out_chan: got %0d want 0", bus.out_chan);
        end
        vectors++;
        if (bus.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
        end
        bus.in_valid = '0;
        apply_reset();
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        mode = 1'b0;
        bus.out_ready = 1'b1;
        set_ch(0, 8'h11);
        set_ch(2, 8'h22);
        bus.in_valid = 4'b0101;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL fixed_ready_0101: got %b want 0001", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_data !== 8'h11 || bus.out_chan !== 2'd0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_out_ch0: got v%b %h/%0d want v1 11/0",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
        bus.in_valid = 4'b0100;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL fixed_ready_0100: got %b want 0100", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_data !== 8'h22 || bus.out_chan !== 2'd2) begin
            miscompares++;
            $display("FAIL fixed_out_ch2: got %h/%0d want 22/2", bus.out_data, bus.out_chan);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mode = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 8'hA0 + 8'(i));
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_chan !== IW'(k % NCH)
                || bus.out_data !== 8'hA0 + 8'(k % NCH)) begin
                miscompares++;
                $display("FAIL rr_seq_%0d: got v%b %h/%0d want v1 %h/%0d", k,
                         bus.out_valid, bus.out_data, bus.out_chan,
                         8'hA0 + 8'(k % NCH), k % NCH);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mode = 1'b0;
        bus.out_ready = 1'b1;
        set_ch(0, 8'h33);
        set_ch(1, 8'h44);
        bus.in_valid = 4'b0001;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_ready_%0d: got %b want 0000", k, bus.in_ready);
            end
            step();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.out_chan !== 2'd0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got v%b %h/%0d want v1 33/0", k,
                         bus.out_valid, bus.out_data, bus.out_chan);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b want 0010", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_data !== 8'h44 || bus.out_chan !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_release_out: got %h/%0d want 44/1", bus.out_data, bus.out_chan);
        end
    endtask

    task automatic test_mode_switch();
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 8'h50 + 8'(i));
        mode = 1'b1;
        bus.in_valid = 4'b1000;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL ms_ready_ch3: got %b want 1000", bus.in_ready);
        end
        step();
        bus.in_valid = 4'b1001;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL ms_wrap_ch0: got %b want 0001", bus.in_ready);
        end
        step();
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 4'b0001) begin
                miscompares++;
                $display("FAIL ms_fixed_%0d: got %b want 0001", k, bus.in_ready);
            end
            step();
        end
        // Pointer must still be 1: back in round-robin, ch1 wins over ch0.
        mode = 1'b1;
        bus.in_valid = 4'b1111;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL ms_ptr_held: got %b want 0010", bus.in_ready);
        end
        step();
    endtask

    task automatic test_async_reset();
        apply_reset();
        mode = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 8'hA0 + 8'(i));
        bus.in_valid = 4'b1111;
        step();
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = '0;
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_out: got v%b %h want v0 00", bus.out_valid, bus.out_data);
        end
        vectors++;
        if (bus.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_ready: got %b want 0000", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL post_reset_rr_start: got %b want 0001", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_chan !== 2'd0 || bus.out_data !== 8'hA0) begin
            miscompares++;
            $display("FAIL post_reset_out: got %h/%0d want a0/0", bus.out_data, bus.out_chan);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        mode = 1'b0;
        bus.out_ready = 1'b1;
        set_ch(0, 8'h5A);
        bus.in_valid = 4'b0001;
        step();
        bus.in_valid = '0;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want 0000", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h5A || bus.out_chan !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_out: got v%b %h/%0d want v0 5a/0",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] er;
        apply_reset();
        mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            bus.in_valid  = NCH'($urandom);
            bus.in_data   = (NCH*DW)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            vectors++;
            if (bus.in_ready !== er) begin
                miscompares++;
                $display("FAIL rand_ready_%0d: got %b want %b", n, bus.in_ready, er);
            end
            step();
            vectors++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data
                || bus.out_chan !== IW'(m_chan)) begin
                miscompares++;
                $display("FAIL rand_out_%0d: got v%b %h/%0d want v%b %h/%0d", n,
                         bus.out_valid, bus.out_data, bus.out_chan,
                         m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        mode          = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_backpressure();
        test_mode_switch();
        test_async_reset();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prio_arb_mux.md
Name: prio_arb_mux

Overview:
- Parametrised N-channel, DATA_W-bit priority multiplexer with a valid/ready handshake on every input and on the output.
- Selects one requesting channel per cycle, in either fixed-priority or round-robin mode, and registers the winner's data and index in a single output stage.
- Used wherever several producers share one datapath consumer. Supersedes the combinational 2:1 priority mux.

Parameters:
NUM_CH, 4, number of input channels (>=1)
DATA_W, 8, data width per channel
IDX_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel index width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
mode  input  1  0 = fixed priority (channel 0 highest), 1 = round-robin
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel request
in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle
out_data  output  DATA_W  registered data of the granted channel
out_chan  output  IDX_W  registered index of the granted channel
out_valid  output  1  output register holds a beat
out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. While reset is asserted, in_ready=0. A beat in flight at reset is discarded.
- load = ~out_valid | out_ready.
  - The output register accepts a new beat only when load=1.
  - Throughput: 1 beat per cycle.
- Grant (combinational, evaluated every cycle):
  - mode=0: grant goes to the lowest index i with in_valid[i]=1.
  - mode=1: grant goes to the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_CH.
  - No in_valid bit set: no grant.
- in_ready[i] = load & grant[i].
  - in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on input i: in_valid[i] & in_ready[i]. At the next rising edge:
  - out_data <= channel i data
  - out_chan <= i
  - out_valid <= 1
  - In round-robin mode only, rr_ptr <= (i+1) mod NUM_CH.
- rr_ptr behaviour:
  - rr_ptr advances only on an accepted transfer in mode=1.
  - rr_ptr is held in mode=0. It is not reset by a mode change.
- Latency: 1 cycle from input transfer to out_valid=1 with that beat's data.
- Output transfer: out_valid & out_ready.
  - If there is a simultaneous input transfer, the register reloads in the same edge, giving back-to-back beats with no bubble.
  - If there is no input transfer, out_valid <= 0. out_data and out_chan hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_chan are stable and all in_ready bits are 0.
- Mode change: takes effect in the same cycle's grant evaluation. A beat already registered is unaffected.
- Wrap-around: when the last channel is granted in round-robin mode, rr_ptr returns to 0.
- NUM_CH=1: always grants channel 0; out_chan=0.
- An in_valid bit dropped before its transfer is legal. It is simply not granted; no state is retained.
- Input data is not held internally beyond the output register. There is no FIFO.

Test Plan:
1. mode=0, NUM_CH=4, in_valid=4'b0101, ch0=0x11, ch2=0x22, out_ready=1. Required: in_ready=4'b0001; next cycle out_data=0x11, out_chan=0. Then drop ch0 valid: ch2 is accepted and out_data=0x22, out_chan=2.
2. mode=1, all four channels valid every cycle with data = 0xA0+i, out_ready=1. Required: out_chan sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
3. Backpressure: out_valid=1 with out_data=0x33, out_ready=0 for 3 cycles while ch1 is valid. Required: in_ready=0, out_data remains 0x33. When out_ready=1, ch1 is accepted in that cycle and out_data=ch1 data on the next cycle.
4. mode=1 with in_valid=4'b1000 granted (rr_ptr becomes 0), then in_valid=4'b1001, then switch to mode=0. Required in mode=1:
   - 4'b1000 grants ch3, wrapping rr_ptr to 0.
   - 4'b1001 grants ch0.
   Required after switching to mode=0: grants stay on ch0 while it remains valid, and rr_ptr stays at 1.
5. Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and out_ready=0. Required: out_valid=0 and out_data=0 immediately, without waiting for a clock edge. After release, the first round-robin grant starts at ch0.
6. Idle: in_valid=0 after one beat with out_ready=1. Required: out_valid falls the next cycle, in_ready=0, and out_data holds its last value.
